// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//  - word width and word type
//  - default reset PC, exception vector and bubble instruction
//  - IF/ID pipeline register payload
//  - PC increment helper (wraps modulo 2^32)
package if_fetch_stage_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t RESET_PC_DEF   = 32'h0000_0000;
    localparam word_t EXC_VECTOR_DEF = 32'h8000_0008;
    localparam word_t NOP_INSTR_DEF  = 32'h0000_0000;

    // Contents of the IF/ID pipeline register
    typedef struct packed {
        logic  valid;
        word_t instr;
        word_t pc4;
    } if_id_t;

    // Sequential successor of a PC; 0xFFFF_FFFC wraps to 0 silently
    function automatic word_t pc_plus4(input word_t pc_in);
        return pc_in + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction ROM.
//  imem_addr : word address presented by the fetch stage (equals PC)
//  imem_data : instruction word returned by the ROM in the same cycle
//  master    : fetch stage side
//  slave     : ROM side
interface if_fetch_stage_if;
    import if_fetch_stage_pkg::*;

    word_t imem_addr;
    word_t imem_data;

    modport master (output imem_addr, input  imem_data);
    modport slave  (input  imem_addr, output imem_data);

endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
//  clk, reset     : clock, asynchronous active-high reset
//  hold           : keep current contents
//  bubble         : load a bubble (valid=0, instr=NOP); pc4 keeps its value; wins over hold
//  load_instr/pc4 : values captured when neither hold nor bubble is active
//  valid/instr/pc4: registered outputs to the decode stage
module if_fetch_stage_if_id_reg
    import if_fetch_stage_pkg::*;
#(
    parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  hold,
    input  logic  bubble,
    input  word_t load_instr,
    input  word_t load_pc4,
    output logic  valid,
    output word_t instr,
    output word_t pc4
);

    if_id_t if_id_r;

    // IF/ID register: bubble beats hold; load_instr is only sampled on a real load,
    // so an undefined ROM word during a stall or bubble never reaches the outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_r.valid <= 1'b0;
            if_id_r.instr <= NOP_INSTR;
            if_id_r.pc4   <= 32'h0000_0000;
        end else if (bubble) begin
            if_id_r.valid <= 1'b0;
            if_id_r.instr <= NOP_INSTR;
            if_id_r.pc4   <= if_id_r.pc4;
        end else if (hold) begin
            if_id_r <= if_id_r;
        end else begin
            if_id_r.valid <= 1'b1;
            if_id_r.instr <= load_instr;
            if_id_r.pc4   <= load_pc4;
        end
    end

    assign valid = if_id_r.valid;
    assign instr = if_id_r.instr;
    assign pc4   = if_id_r.pc4;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
//  clk, reset   : core clock, asynchronous active-high reset
//  stall        : hold PC and IF/ID
//  flush        : bubble IF/ID on the next edge (PC unaffected)
//  redirect     : taken branch / j / jal / jr, target on redirect_pc
//  exc_req      : exception/interrupt entry, highest priority
//  imem         : instruction ROM bus (address = PC, data same cycle)
//  pc           : current PC register
//  if_id_*      : IF/ID pipeline register towards decode
//  misalign     : one-cycle pulse after an accepted redirect with target[1:0] != 0
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter word_t RESET_PC   = RESET_PC_DEF,
    parameter word_t EXC_VECTOR = EXC_VECTOR_DEF,
    parameter word_t NOP_INSTR  = NOP_INSTR_DEF
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  stall,
    input  logic  flush,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  exc_req,
    if_fetch_stage_if.master imem,
    output word_t pc,
    output logic  if_id_valid,
    output word_t if_id_instr,
    output word_t if_id_pc4,
    output logic  misalign
);

    word_t pc_r;
    word_t pc_next_s;
    word_t pc_seq_s;
    logic  redirect_accept_s;
    logic  misalign_next_s;
    logic  misalign_r;

    assign pc_seq_s = pc_plus4(pc_r);

    // A redirect only takes effect when neither an exception nor a stall pre-empts it;
    // a stalled redirect is expected to be held by its source
    assign redirect_accept_s = redirect & ~stall & ~exc_req;

    // Next-PC selection: exception > stall > redirect > sequential
    always_comb begin
        pc_next_s = pc_seq_s;
        if (exc_req) begin
            pc_next_s = EXC_VECTOR;
        end else if (stall) begin
            pc_next_s = pc_r;
        end else if (redirect) begin
            pc_next_s = {redirect_pc[31:2], 2'b00};
        end else begin
            pc_next_s = pc_seq_s;
        end
    end

    // Misalignment flag for the redirect accepted this cycle
    always_comb begin
        misalign_next_s = 1'b0;
        if (redirect_accept_s) begin
            misalign_next_s = |redirect_pc[1:0];
        end else begin
            misalign_next_s = 1'b0;
        end
    end

    // PC register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Misalign pulse register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= misalign_next_s;
        end
    end

    // Exception entry squashes the fetched word even when stalled
    if_fetch_stage_if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .reset      (reset),
        .hold       (stall),
        .bubble     (exc_req | flush),
        .load_instr (imem.imem_data),
        .load_pc4   (pc_seq_s),
        .valid      (if_id_valid),
        .instr      (if_id_instr),
        .pc4        (if_id_pc4)
    );

    assign imem.imem_addr = pc_r;
    assign pc             = pc_r;
    assign misalign       = misalign_r;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a small ROM holding the recursive sum(3) program.
module tb_if_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        exc_req;
    logic [31:0] pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        misalign;

    int vectors;
    int miscompares;

    if_fetch_stage_if bus ();

    if_fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .exc_req     (exc_req),
        .imem        (bus.master),
        .pc          (pc),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .misalign    (misalign)
    );

    // Recursive sum(3): main at 0x00, jal sum at 0x04, sum body at 0x0C
    function automatic logic [31:0] rom_word(input logic [3:0] idx);
        case (idx)
            4'd0:    return 32'h2004_0003; // addi $a0,$zero,3
            4'd1:    return 32'h0C00_0003; // jal  sum
            4'd2:    return 32'h0000_0000; // nop (delay slot)
            4'd3:    return 32'h27BD_FFF8; // sum: addiu $sp,$sp,-8
            4'd4:    return 32'hAFBF_0004; // sw $ra,4($sp)
            4'd5:    return 32'hAFA4_0000; // sw $a0,0($sp)
            4'd6:    return 32'h1080_0006; // beq $a0,$zero,base
            4'd7:    return 32'h0000_0000;
            4'd8:    return 32'h2084_FFFF; // addi $a0,$a0,-1
            4'd9:    return 32'h0C00_0003; // jal sum
            4'd10:   return 32'h0000_0000;
            4'd11:   return 32'h8FA4_0000; // lw $a0,0($sp)
            4'd12:   return 32'h0082_1020; // add $v0,$a0,$v0
            4'd13:   return 32'h8FBF_0004; // lw $ra,4($sp)
            4'd14:   return 32'h03E0_0008; // jr $ra
            default: return 32'h27BD_0008; // addiu $sp,$sp,8
        endcase
    endfunction

    assign bus.imem_data = rom_word(bus.imem_addr[5:2]);

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        mis;
    } exp_t;

    exp_t q[$];

    // Reference state of the fetch stage
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_mis;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0000_0000;
        m_valid = 1'b0;
        m_instr = 32'h0000_0000;
        m_pc4   = 32'h0000_0000;
        m_mis   = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".pc"},    pc,                  m_pc);
        chk({tag, ".addr"},  bus.imem_addr,       m_pc);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
        chk({tag, ".instr"}, if_id_instr,         m_instr);
        chk({tag, ".pc4"},   if_id_pc4,           m_pc4);
        chk({tag, ".mis"},   {31'd0, misalign},   {31'd0, m_mis});
    endtask

    // Drive one cycle of hazard inputs, predict the edge, then compare after it
    task automatic step(input string tag, input logic st, input logic fl, input logic rd,
                        input logic [31:0] rpc, input logic ex);
        exp_t e;
        logic [31:0] n_pc;
        stall = st; flush = fl; redirect = rd; redirect_pc = rpc; exc_req = ex;
        if (ex)      n_pc = 32'h8000_0008;
        else if (st) n_pc = m_pc;
        else if (rd) n_pc = {rpc[31:2], 2'b00};
        else         n_pc = m_pc + 32'd4;
        if (ex || fl) begin
            m_valid = 1'b0; m_instr = 32'h0000_0000;
        end else if (!st) begin
            m_valid = 1'b1; m_instr = rom_word(m_pc[5:2]); m_pc4 = m_pc + 32'd4;
        end
        m_mis = rd && !st && !ex && (rpc[1:0] != 2'b00);
        m_pc  = n_pc;
        e.pc = m_pc; e.valid = m_valid; e.instr = m_instr; e.pc4 = m_pc4; e.mis = m_mis;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({tag, ".pc"},    pc,                   e.pc);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e.valid});
        chk({tag, ".instr"}, if_id_instr,          e.instr);
        chk({tag, ".pc4"},   if_id_pc4,            e.pc4);
        chk({tag, ".mis"},   {31'd0, misalign},    {31'd0, e.mis});
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; exc_req = 1'b0;
        reset = 1'b1;
        model_reset();

        // 1: reset held for 3 cycles, then sequential fetch
        repeat (3) @(posedge clk);
        #1;
        check_state("reset");
        reset = 1'b0;
        step("seq0", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("seq0.first_instr", if_id_instr, 32'h2004_0003);
        chk("seq0.first_pc4",   if_id_pc4,   32'h0000_0004);
        step("seq1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("seq1.pc", pc, 32'h0000_0008);

        // 2: jal redirect to sum at 0x0C; jal word carries pc4 = 0x08
        chk("jal.pc4", if_id_pc4, 32'h0000_0008);
        step("redir", 1'b0, 1'b0, 1'b1, 32'h0000_000C, 1'b0);
        chk("redir.pc", pc, 32'h0000_000C);

        // 3: stall with pending redirect, then redirect taken once stall drops
        step("stall0", 1'b1, 1'b0, 1'b1, 32'h0000_002C, 1'b0);
        step("stall1", 1'b1, 1'b0, 1'b1, 32'h0000_002C, 1'b0);
        step("unstall", 1'b0, 1'b0, 1'b1, 32'h0000_002C, 1'b0);
        chk("unstall.pc", pc, 32'h0000_002C);

        // 4: flush with stall -> bubble, PC frozen; then flush alone
        step("flstall", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("flstall.pc", pc, 32'h0000_002C);
        step("flush", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

        // 5: exception beats stall and redirect; then misaligned redirect
        step("exc", 1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b1);
        chk("exc.pc", pc, 32'h8000_0008);
        step("mis", 1'b0, 1'b0, 1'b1, 32'h0000_000E, 1'b0);
        chk("mis.pulse", {31'd0, misalign}, 32'd1);
        step("mis_end", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("mis_stall", 1'b1, 1'b0, 1'b1, 32'h0000_0011, 1'b0);

        // 6: async reset in the middle of a redirect cycle, then PC wrap
        redirect = 1'b1; redirect_pc = 32'h0000_002C;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_state("areset");
        @(posedge clk);
        #1;
        redirect = 1'b0;
        reset = 1'b0;
        check_state("areset_hold");
        step("post_rst", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step("to_top", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        step("wrap", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("wrap.pc",  pc,        32'h0000_0000);
        chk("wrap.pc4", if_id_pc4, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
